// File: rtl/frame_byte_reader.sv
// -----------------------------------------------------------------------------
// frame_byte_reader
//
// Drain side of the ping-pong sample buffer. A one-cycle buffer_ready_i pulse
// starts a frame: DEPTH signed samples are pulled over the buffer's
// valid/ready read port, and each one is serialised MSB byte first onto an
// 8-bit valid/ready byte stream that feeds the host link bridge.
// Samples are sent as raw two's-complement bits.
//
// Optional feature macro: FRAME_READER_HEADER_EN
//   defined   : every frame is prefixed by one SYNC_BYTE (HEADER state present)
//   undefined : IDLE goes straight to LOAD, frame is DEPTH*WIDTH/8 bytes
//
// Ports
//   clk_i           system clock
//   rst_ni          asynchronous active-low reset
//   buffer_ready_i  1-cycle pulse, a full frame is available
//   sample_data_i   sample from the buffer read port (signed, WIDTH bits)
//   sample_valid_i  sample_data_i valid
//   sample_ready_o  reader accepts a sample this cycle (high only in LOAD)
//   byte_data_o     serial byte out (registered)
//   byte_valid_o    byte_data_o valid (registered)
//   byte_ready_i    downstream accepts the byte
//   busy_o          FSM not in IDLE
//   frame_done_o    1-cycle pulse after the last byte of a frame is accepted
//   frame_drop_o    1-cycle pulse, buffer_ready_i arrived while busy
//   sample_count_o  samples consumed in the current frame
// -----------------------------------------------------------------------------
module frame_byte_reader #(
    parameter int         WIDTH      = 32,
    parameter int         DEPTH      = 16,
    parameter int         ADDR_WIDTH = $clog2(DEPTH),
    parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    buffer_ready_i,
    input  logic signed [WIDTH-1:0] sample_data_i,
    input  logic                    sample_valid_i,
    output logic                    sample_ready_o,
    output logic [7:0]              byte_data_o,
    output logic                    byte_valid_o,
    input  logic                    byte_ready_i,
    output logic                    busy_o,
    output logic                    frame_done_o,
    output logic                    frame_drop_o,
    output logic [ADDR_WIDTH:0]     sample_count_o
);

    localparam int BYTES_PER_SAMPLE = WIDTH / 8;
    localparam int IDX_W            = (BYTES_PER_SAMPLE > 1) ? $clog2(BYTES_PER_SAMPLE) : 1;

    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(BYTES_PER_SAMPLE - 1);
    localparam logic [IDX_W-1:0]    IDX_ONE  = IDX_W'(1);
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH + 1)'(1);

    localparam logic [2:0] S_IDLE   = 3'd0;
`ifdef FRAME_READER_HEADER_EN
    localparam logic [2:0] S_HEADER = 3'd1;
`endif
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_SHIFT  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [WIDTH-1:0]      shreg_q, shreg_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  byte_valid_q, byte_valid_d;
    logic [7:0]            byte_data_q, byte_data_d;
    logic                  frame_done_q, frame_done_d;
    logic                  frame_drop_q, frame_drop_d;
    logic [WIDTH-1:0]      shreg_shift_s;

`ifndef FRAME_READER_HEADER_EN
    // The sync byte has no consumer without the header state.
    logic unused_sync_s;
    assign unused_sync_s = ^SYNC_BYTE;
`endif

    assign shreg_shift_s = shreg_q << 4'd8;

    // Next-state and datapath decode for the frame FSM.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        idx_d        = idx_q;
        count_d      = count_q;
        byte_valid_d = byte_valid_q;
        byte_data_d  = byte_data_q;
        frame_done_d = 1'b0;
        // Any start request outside IDLE (DONE included) is discarded and flagged.
        frame_drop_d = buffer_ready_i && (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (buffer_ready_i) begin
                    count_d = '0;
                    idx_d   = '0;
`ifdef FRAME_READER_HEADER_EN
                    state_d      = S_HEADER;
                    byte_valid_d = 1'b1;
                    byte_data_d  = SYNC_BYTE;
`else
                    state_d      = S_LOAD;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
`ifdef FRAME_READER_HEADER_EN
            S_HEADER: begin
                if (byte_ready_i) begin
                    state_d      = S_LOAD;
                    byte_valid_d = 1'b0;
                end else begin
                    state_d = S_HEADER;
                end
            end
`endif
            S_LOAD: begin
                if (sample_valid_i) begin
                    shreg_d      = sample_data_i;
                    count_d      = count_q + CNT_ONE;
                    idx_d        = '0;
                    state_d      = S_SHIFT;
                    byte_valid_d = 1'b1;
                    byte_data_d  = sample_data_i[WIDTH-1 -: 8];
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_SHIFT: begin
                if (byte_ready_i) begin
                    if (idx_q == LAST_IDX) begin
                        byte_valid_d = 1'b0;
                        if (count_q == DEPTH_C) begin
                            state_d      = S_DONE;
                            frame_done_d = 1'b1;
                        end else begin
                            state_d = S_LOAD;
                        end
                    end else begin
                        // Next byte is taken from the already-shifted register so it
                        // is valid on the cycle right after the accept.
                        shreg_d     = shreg_shift_s;
                        idx_d       = idx_q + IDX_ONE;
                        byte_data_d = shreg_shift_s[WIDTH-1 -: 8];
                    end
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d      = S_IDLE;
                byte_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            idx_q        <= '0;
            count_q      <= '0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= 8'h00;
            frame_done_q <= 1'b0;
            frame_drop_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            idx_q        <= idx_d;
            count_q      <= count_d;
            byte_valid_q <= byte_valid_d;
            byte_data_q  <= byte_data_d;
            frame_done_q <= frame_done_d;
            frame_drop_q <= frame_drop_d;
        end
    end

    assign sample_ready_o = (state_q == S_LOAD);
    assign busy_o         = (state_q != S_IDLE);
    assign byte_valid_o   = byte_valid_q;
    assign byte_data_o    = byte_data_q;
    assign frame_done_o   = frame_done_q;
    assign frame_drop_o   = frame_drop_q;
    assign sample_count_o = count_q;

endmodule

// File: tb/tb_frame_byte_reader.sv
module tb_frame_byte_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // DUT A: WIDTH=16, DEPTH=4
    logic        br_a, sv_a, sr_a, bv_a, brdy_a, busy_a, done_a, drop_a;
    logic [15:0] sd_a;
    logic [7:0]  bd_a;
    logic [2:0]  cnt_a;

    // DUT B: WIDTH=32, DEPTH=2
    logic        br_b, sv_b, sr_b, bv_b, brdy_b, busy_b, done_b, drop_b;
    logic [31:0] sd_b;
    logic [7:0]  bd_b;
    logic [1:0]  cnt_b;

    frame_byte_reader #(.WIDTH(16), .DEPTH(4)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .buffer_ready_i(br_a),
        .sample_data_i(sd_a), .sample_valid_i(sv_a), .sample_ready_o(sr_a),
        .byte_data_o(bd_a), .byte_valid_o(bv_a), .byte_ready_i(brdy_a),
        .busy_o(busy_a), .frame_done_o(done_a), .frame_drop_o(drop_a),
        .sample_count_o(cnt_a)
    );

    frame_byte_reader #(.WIDTH(32), .DEPTH(2)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .buffer_ready_i(br_b),
        .sample_data_i(sd_b), .sample_valid_i(sv_b), .sample_ready_o(sr_b),
        .byte_data_o(bd_b), .byte_valid_o(bv_b), .byte_ready_i(brdy_b),
        .busy_o(busy_b), .frame_done_o(done_b), .frame_drop_o(drop_b),
        .sample_count_o(cnt_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] smp [4];
    logic [7:0]  exp16 [9];
    int          n_exp16;

    // Results recorded by the frame driver
    logic [7:0]  got [16];
    int          n_got, n_done, n_drop, n_hold_bad, stall_ok;
    logic [2:0]  cnt_at_done, first_cnt;
    logic        first_valid, first_sready, busy_after, aborted;
    logic [7:0]  first_data;

    // Runs one frame on DUT A: ready_mode 0 = always ready, 1 = toggling;
    // drop_si/stall_si/abort_si select a sample index for a side event (-1 off).
    task automatic run_frame(input int ready_mode, input int drop_si,
                             input int stall_si, input int abort_si);
        int si, post, stall_left;
        logic prev_stall, drop_sent;
        logic [7:0] prev_data;
        si = 0; post = 0; stall_left = 5; prev_stall = 1'b0; drop_sent = 1'b0;
        prev_data = 8'h00;
        n_got = 0; n_done = 0; n_drop = 0; n_hold_bad = 0; stall_ok = 0;
        cnt_at_done = 3'd7; busy_after = 1'b1; aborted = 1'b0;
        @(negedge clk);
        br_a = 1'b1; sv_a = 1'b0; brdy_a = 1'b0;
        @(negedge clk);
        br_a = 1'b0;
        first_valid = bv_a; first_data = bd_a; first_sready = sr_a; first_cnt = cnt_a;
        for (int k = 0; k < 300; k++) begin
            if (k > 0) @(negedge clk);
            if (abort_si > 0 && si == abort_si && bv_a) begin
                aborted = 1'b1;
                break;
            end
            if (prev_stall && (bd_a !== prev_data || bv_a !== 1'b1)) n_hold_bad++;
            if (done_a) begin n_done++; cnt_at_done = cnt_a; end
            if (drop_a) n_drop++;
            br_a   = 1'b0;
            brdy_a = (ready_mode == 1) ? (k % 2 == 0) : 1'b1;
            if (si == stall_si && stall_left > 0 && sr_a) begin
                sv_a = 1'b0;
                if (!bv_a && cnt_a == 3'(si)) stall_ok++;
                stall_left--;
            end else if (si < 4) begin
                sv_a = 1'b1;
                sd_a = smp[si];
                if (sr_a) si++;
            end else begin
                sv_a = 1'b0;
                sd_a = 16'h0000;
            end
            if (drop_si >= 0 && si == drop_si && !drop_sent) begin
                br_a = 1'b1;
                drop_sent = 1'b1;
            end
            if (bv_a && brdy_a) begin
                if (n_got < 16) got[n_got] = bd_a;
                n_got++;
            end
            prev_stall = bv_a && !brdy_a;
            prev_data  = bd_a;
            if (n_done > 0) begin
                post++;
                if (post == 2) busy_after = busy_a;
                if (post >= 4) break;
            end
        end
        sv_a = 1'b0; brdy_a = 1'b0; br_a = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_cmp++;
        if ({bv_a, bd_a, sr_a, busy_a, done_a, drop_a, cnt_a} !== 15'h0) begin
            n_bad++;
            $display("FAIL reset_a: got %h expected 0", {bv_a, bd_a, sr_a, busy_a, done_a, drop_a, cnt_a});
        end
        n_cmp++;
        if ({bv_b, bd_b, sr_b, busy_b, done_b, drop_b, cnt_b} !== 14'h0) begin
            n_bad++;
            $display("FAIL reset_b: got %h expected 0", {bv_b, bd_b, sr_b, busy_b, done_b, drop_b, cnt_b});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        smp[0] = 16'h1234; smp[1] = 16'hABCD; smp[2] = 16'h8001; smp[3] = 16'h7FFF;
        run_frame(0, -1, -1, -1);
`ifdef FRAME_READER_HEADER_EN
        n_cmp++;
        if (first_valid !== 1'b1 || first_data !== 8'hA5) begin
            n_bad++;
            $display("FAIL basic_latency: got valid=%b data=%h expected valid=1 data=a5", first_valid, first_data);
        end
`else
        n_cmp++;
        if (first_sready !== 1'b1 || first_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_latency: got sready=%b valid=%b expected sready=1 valid=0", first_sready, first_valid);
        end
`endif
        n_cmp++;
        if (first_cnt !== 3'd0) begin
            n_bad++; $display("FAIL basic_start_count: got %0d expected 0", first_cnt);
        end
        n_cmp++;
        if (n_got !== n_exp16) begin
            n_bad++; $display("FAIL basic_nbytes: got %0d expected %0d", n_got, n_exp16);
        end
        for (int i = 0; i < n_exp16; i++) begin
            n_cmp++;
            if (got[i] !== exp16[i]) begin
                n_bad++; $display("FAIL basic_byte%0d: got %h expected %h", i, got[i], exp16[i]);
            end
        end
        n_cmp++;
        if (n_done !== 1) begin
            n_bad++; $display("FAIL basic_done: got %0d pulses expected 1", n_done);
        end
        n_cmp++;
        if (cnt_at_done !== 3'd4) begin
            n_bad++; $display("FAIL basic_count_done: got %0d expected 4", cnt_at_done);
        end
        n_cmp++;
        if (busy_after !== 1'b0 || n_drop !== 0) begin
            n_bad++; $display("FAIL basic_idle: got busy=%b drops=%0d expected 0/0", busy_after, n_drop);
        end
        n_cmp++;
        if (cnt_a !== 3'd4) begin
            n_bad++; $display("FAIL basic_count_hold: got %0d expected 4", cnt_a);
        end
    endtask

    task automatic test_backpressure();
        run_frame(1, -1, -1, -1);
        n_cmp++;
        if (n_got !== n_exp16) begin
            n_bad++; $display("FAIL bp_nbytes: got %0d expected %0d", n_got, n_exp16);
        end
        for (int i = 0; i < n_exp16; i++) begin
            n_cmp++;
            if (got[i] !== exp16[i]) begin
                n_bad++; $display("FAIL bp_byte%0d: got %h expected %h", i, got[i], exp16[i]);
            end
        end
        n_cmp++;
        if (n_hold_bad !== 0) begin
            n_bad++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", n_hold_bad);
        end
        n_cmp++;
        if (n_done !== 1) begin
            n_bad++; $display("FAIL bp_done: got %0d expected 1", n_done);
        end
    endtask

    task automatic test_drop();
        run_frame(0, 2, -1, -1);
        n_cmp++;
        if (n_drop !== 1) begin
            n_bad++; $display("FAIL drop_pulse: got %0d expected 1", n_drop);
        end
        n_cmp++;
        if (n_got !== n_exp16 || got[n_exp16-1] !== 8'hFF) begin
            n_bad++; $display("FAIL drop_bytes: got %0d bytes last=%h expected %0d last=ff", n_got, got[n_exp16-1], n_exp16);
        end
        n_cmp++;
        if (n_done !== 1) begin
            n_bad++; $display("FAIL drop_done: got %0d expected 1", n_done);
        end
    endtask

    task automatic test_stall();
        run_frame(0, -1, 1, -1);
        n_cmp++;
        if (stall_ok !== 5) begin
            n_bad++; $display("FAIL stall_cycles: got %0d good cycles expected 5", stall_ok);
        end
        n_cmp++;
        if (n_got !== n_exp16) begin
            n_bad++; $display("FAIL stall_nbytes: got %0d expected %0d", n_got, n_exp16);
        end
        for (int i = 0; i < n_exp16; i++) begin
            n_cmp++;
            if (got[i] !== exp16[i]) begin
                n_bad++; $display("FAIL stall_byte%0d: got %h expected %h", i, got[i], exp16[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int stray;
        run_frame(0, -1, -1, 2);
        n_cmp++;
        if (aborted !== 1'b1) begin
            n_bad++; $display("FAIL rstmid_reach: got aborted=%b expected 1", aborted);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bv_a, bd_a, sr_a, busy_a, done_a, drop_a, cnt_a} !== 15'h0) begin
            n_bad++;
            $display("FAIL rstmid_async: got %h expected 0", {bv_a, bd_a, sr_a, busy_a, done_a, drop_a, cnt_a});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        repeat (5) begin
            @(negedge clk);
            if (bv_a || done_a || busy_a) stray++;
        end
        n_cmp++;
        if (stray !== 0) begin
            n_bad++; $display("FAIL rstmid_no_resume: got %0d active cycles expected 0", stray);
        end
        run_frame(0, -1, -1, -1);
        n_cmp++;
        if (first_cnt !== 3'd0) begin
            n_bad++; $display("FAIL rstmid_count: got %0d expected 0", first_cnt);
        end
`ifdef FRAME_READER_HEADER_EN
        n_cmp++;
        if (first_valid !== 1'b1 || first_data !== 8'hA5) begin
            n_bad++; $display("FAIL rstmid_header: got valid=%b data=%h expected 1/a5", first_valid, first_data);
        end
`else
        n_cmp++;
        if (first_sready !== 1'b1) begin
            n_bad++; $display("FAIL rstmid_load: got sready=%b expected 1", first_sready);
        end
`endif
        n_cmp++;
        if (n_got !== n_exp16 || n_done !== 1) begin
            n_bad++; $display("FAIL rstmid_frame: got %0d bytes %0d done expected %0d/1", n_got, n_done, n_exp16);
        end
    endtask

    task automatic test_wide();
        logic [31:0] w [2];
        logic [7:0]  e [9];
        logic [7:0]  g [12];
        logic [1:0]  cd;
        int ne, nb, nd, wi;
        w[0] = 32'hDEADBEEF; w[1] = 32'h00000001;
`ifdef FRAME_READER_HEADER_EN
        e = '{8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h01}; ne = 9;
`else
        e = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00}; ne = 8;
`endif
        nb = 0; nd = 0; wi = 0; cd = 2'd3;
        @(negedge clk);
        br_b = 1'b1; brdy_b = 1'b1;
        @(negedge clk);
        br_b = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (k > 0) @(negedge clk);
            if (done_b) begin nd++; cd = cnt_b; end
            if (wi < 2) begin
                sv_b = 1'b1; sd_b = w[wi];
                if (sr_b) wi++;
            end else begin
                sv_b = 1'b0;
            end
            if (bv_b && brdy_b) begin
                if (nb < 12) g[nb] = bd_b;
                nb++;
            end
            if (nd > 0) break;
        end
        sv_b = 1'b0; brdy_b = 1'b0;
        n_cmp++;
        if (nb !== ne) begin
            n_bad++; $display("FAIL wide_nbytes: got %0d expected %0d", nb, ne);
        end
        for (int i = 0; i < ne; i++) begin
            n_cmp++;
            if (g[i] !== e[i]) begin
                n_bad++; $display("FAIL wide_byte%0d: got %h expected %h", i, g[i], e[i]);
            end
        end
        n_cmp++;
        if (nd !== 1 || cd !== 2'd2) begin
            n_bad++; $display("FAIL wide_done: got done=%0d count=%0d expected 1/2", nd, cd);
        end
    endtask

    initial begin
        br_a = 1'b0; sv_a = 1'b0; brdy_a = 1'b0; sd_a = 16'h0000;
        br_b = 1'b0; sv_b = 1'b0; brdy_b = 1'b0; sd_b = 32'h0000_0000;
        rst_n = 1'b1;
`ifdef FRAME_READER_HEADER_EN
        exp16 = '{8'hA5, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h80, 8'h01, 8'h7F, 8'hFF};
        n_exp16 = 9;
`else
        exp16 = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h80, 8'h01, 8'h7F, 8'hFF, 8'h00};
        n_exp16 = 8;
`endif
        test_reset();
        test_basic();
        test_backpressure();
        test_drop();
        test_stall();
        test_reset_mid();
        test_wide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
